// File: rtl/vga_mode_sequencer_if.sv
// Mode/palette control bundle between the board-side controls, the
// mode sequencer and the VGA pattern generator's mode/palette inputs.
interface vga_mode_sequencer_if;
    logic       ena;
    logic       frame_start;
    logic       auto_en;
    logic [2:0] manual_mode;
    logic [4:0] pal_base;
    logic       scroll_en;
    logic       step_req;
    logic [2:0] mode_out;
    logic [4:0] pal_out;
    logic       mode_changed;
    logic       step_ack;

    // Board/controller side: drives the controls, observes the sequencer.
    modport master (
        output ena, frame_start, auto_en, manual_mode, pal_base, scroll_en, step_req,
        input  mode_out, pal_out, mode_changed, step_ack
    );

    // Sequencer side.
    modport slave (
        input  ena, frame_start, auto_en, manual_mode, pal_base, scroll_en, step_req,
        output mode_out, pal_out, mode_changed, step_ack
    );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Frame-synchronous mode/palette sequencer for the 640x480 pattern generator.
// Pattern and palette only change on the clock after a frame_start strobe,
// so a frame never mixes two patterns. Manual mode passes the selection
// through; auto mode runs a timed slideshow that a step request can advance
// early. An optional rolling offset is added to the palette base.
module vga_mode_sequencer #(
    parameter int NUM_MODES    = 6,
    parameter int DWELL_FRAMES = 120,
    parameter int PAL_DIV      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_mode_sequencer_if.slave  bus
);
    typedef enum logic {S_MANUAL = 1'b0, S_AUTO = 1'b1} state_t;

    localparam logic [2:0] LAST_IDX  = 3'(NUM_MODES - 1);
    localparam logic [3:0] MODE_LIM  = 4'(NUM_MODES);
    localparam logic [7:0] DWELL_RLD = 8'(DWELL_FRAMES - 1);
    localparam logic [7:0] DIV_LAST  = 8'(PAL_DIV - 1);

    state_t     r_state,        w_state;
    logic [2:0] r_mode,         w_mode;
    logic [4:0] r_pal,          w_pal;
    logic       r_mode_changed, w_mode_changed;
    logic       r_step_ack,     w_step_ack;
    logic [7:0] r_dwell,        w_dwell;
    logic [2:0] r_auto_idx,     w_auto_idx;
    logic [4:0] r_pal_off,      w_pal_off;
    logic [7:0] r_div_cnt,      w_div_cnt;
    logic       r_step_pend,    w_step_pend;

    // A request coincident with frame_start counts for that frame.
    logic       w_step_any;
    logic [2:0] w_idx_inc;
    assign w_step_any = r_step_pend | bus.step_req;
    assign w_idx_inc  = (r_auto_idx == LAST_IDX) ? 3'd0 : r_auto_idx + 3'd1;

    // Next-state and output decode; nothing but step_pend moves off a frame boundary.
    always_comb begin
        w_state        = r_state;
        w_mode         = r_mode;
        w_pal          = r_pal;
        w_mode_changed = 1'b0;
        w_step_ack     = 1'b0;
        w_dwell        = r_dwell;
        w_auto_idx     = r_auto_idx;
        w_pal_off      = r_pal_off;
        w_div_cnt      = r_div_cnt;
        w_step_pend    = w_step_any;

        if (!bus.ena) begin
            w_state     = S_MANUAL;
            w_mode      = 3'd0;
            w_pal       = 5'd0;
            w_dwell     = 8'd0;
            w_auto_idx  = 3'd0;
            w_pal_off   = 5'd0;
            w_div_cnt   = 8'd0;
            w_step_pend = 1'b0;
        end else if (bus.frame_start) begin
            case (r_state)
                S_MANUAL: begin
                    // Pending steps never survive manual mode.
                    w_step_pend = 1'b0;
                    if (!bus.auto_en) begin
                        w_mode = bus.manual_mode;
                    end else begin
                        // Resume the slideshow from the current pattern when it is in range.
                        w_state    = S_AUTO;
                        w_auto_idx = ({1'b0, r_mode} < MODE_LIM) ? r_mode : 3'd0;
                        w_mode     = w_auto_idx;
                        w_dwell    = DWELL_RLD;
                    end
                end
                S_AUTO: begin
                    if (!bus.auto_en) begin
                        w_state     = S_MANUAL;
                        w_mode      = bus.manual_mode;
                        w_step_pend = 1'b0;
                    end else if (w_step_any || (r_dwell == 8'd0)) begin
                        w_auto_idx  = w_idx_inc;
                        w_mode      = w_idx_inc;
                        w_dwell     = DWELL_RLD;
                        w_step_ack  = w_step_any;
                        w_step_pend = 1'b0;
                    end else begin
                        w_dwell = r_dwell - 8'd1;
                    end
                end
                default: w_state = S_MANUAL;
            endcase

            w_mode_changed = (w_mode != r_mode);

            if (bus.scroll_en) begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_cnt = 8'd0;
                    w_pal_off = r_pal_off + 5'd1;
                end else begin
                    w_div_cnt = r_div_cnt + 8'd1;
                end
            end else begin
                w_div_cnt = 8'd0;
            end
            // 5-bit add wraps modulo 32.
            w_pal = bus.pal_base + w_pal_off;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_MANUAL;
            r_mode         <= 3'd0;
            r_pal          <= 5'd0;
            r_mode_changed <= 1'b0;
            r_step_ack     <= 1'b0;
            r_dwell        <= 8'd0;
            r_auto_idx     <= 3'd0;
            r_pal_off      <= 5'd0;
            r_div_cnt      <= 8'd0;
            r_step_pend    <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_mode         <= w_mode;
            r_pal          <= w_pal;
            r_mode_changed <= w_mode_changed;
            r_step_ack     <= w_step_ack;
            r_dwell        <= w_dwell;
            r_auto_idx     <= w_auto_idx;
            r_pal_off      <= w_pal_off;
            r_div_cnt      <= w_div_cnt;
            r_step_pend    <= w_step_pend;
        end
    end

    assign bus.mode_out     = r_mode;
    assign bus.pal_out      = r_pal;
    assign bus.mode_changed = r_mode_changed;
    assign bus.step_ack     = r_step_ack;
endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Bench for vga_mode_sequencer: directed scenarios followed by random
// stimulus, every cycle compared against a frame-level behavioural model.
module tb_vga_mode_sequencer;
    localparam int NM = 6;
    localparam int DW = 3;
    localparam int PD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_mode_sequencer_if bus ();

    vga_mode_sequencer #(
        .NUM_MODES    (NM),
        .DWELL_FRAMES (DW),
        .PAL_DIV      (PD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: frames already shown for the current slideshow pattern, and the
    // length of the current run of scrolling frames.
    bit m_auto, m_pend, m_mc, m_ack;
    int m_idx, m_shown, m_mode, m_off, m_run, m_pal;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_auto = 0; m_pend = 0; m_mc = 0; m_ack = 0;
        m_idx = 0; m_shown = 0; m_mode = 0; m_off = 0; m_run = 0; m_pal = 0;
    endfunction

    function automatic void model_edge();
        int  nm;
        bit  stp;
        if (rst || !bus.ena) begin
            model_reset();
        end else if (!bus.frame_start) begin
            m_pend = m_pend | bus.step_req;
            m_mc = 0;
            m_ack = 0;
        end else begin
            stp   = m_pend | bus.step_req;
            nm    = m_mode;
            m_ack = 0;
            if (!m_auto) begin
                m_pend = 0;
                if (!bus.auto_en) nm = bus.manual_mode;
                else begin
                    m_auto  = 1;
                    m_idx   = (m_mode < NM) ? m_mode : 0;
                    nm      = m_idx;
                    m_shown = 1;
                end
            end else if (!bus.auto_en) begin
                m_auto = 0;
                m_pend = 0;
                nm     = bus.manual_mode;
            end else if (stp || m_shown >= DW) begin
                m_idx   = (m_idx + 1) % NM;
                nm      = m_idx;
                m_shown = 1;
                m_ack   = stp;
                m_pend  = 0;
            end else begin
                m_shown++;
            end
            m_mc   = (nm != m_mode);
            m_mode = nm;
            if (bus.scroll_en) begin
                m_run++;
                if (m_run % PD == 0) m_off = (m_off + 1) % 32;
            end else begin
                m_run = 0;
            end
            m_pal = (bus.pal_base + m_off) % 32;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_val("mode_out", bus.mode_out, m_mode);
        check_val("pal_out", bus.pal_out, m_pal);
        check_val("mode_changed", bus.mode_changed, m_mc);
        check_val("step_ack", bus.step_ack, m_ack);
    endtask

    task automatic frame(input int idle);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (idle) tick();
    endtask

    int pal_seq [6] = '{30, 31, 31, 0, 0, 1};

    initial begin
        rst = 1'b1;
        bus.ena = 1'b1; bus.frame_start = 1'b0; bus.auto_en = 1'b0;
        bus.manual_mode = 3'd0; bus.pal_base = 5'd0; bus.scroll_en = 1'b0; bus.step_req = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        check_val("reset_mode", bus.mode_out, 0);

        // Asynchronous reset mid-frame
        bus.manual_mode = 3'd3; bus.pal_base = 5'd12;
        frame(3);
        check_val("pre_rst_mode", bus.mode_out, 3);
        rst = 1'b1;
        #1;
        model_reset();
        check_val("async_rst_mode", bus.mode_out, 0);
        check_val("async_rst_pal", bus.pal_out, 0);
        tick();
        rst = 1'b0;

        // ena low holds everything at reset values
        bus.ena = 1'b0; bus.auto_en = 1'b1; bus.scroll_en = 1'b1; bus.step_req = 1'b1;
        frame(3);
        frame(3);
        check_val("ena_low_mode", bus.mode_out, 0);
        bus.ena = 1'b1; bus.auto_en = 1'b0; bus.scroll_en = 1'b0; bus.step_req = 1'b0;
        bus.pal_base = 5'd0;

        // Manual pass-through
        bus.manual_mode = 3'd5;
        frame(0);
        check_val("man5_mode", bus.mode_out, 5);
        check_val("man5_chg", bus.mode_changed, 1);
        repeat (2) tick();
        frame(0);
        check_val("man5_rechg", bus.mode_changed, 0);
        repeat (2) tick();
        bus.manual_mode = 3'd7;
        frame(2);
        check_val("man7_mode", bus.mode_out, 7);

        // Auto dwell and wrap, entered from out-of-range mode 7
        bus.auto_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            bus.frame_start = 1'b1;
            tick();
            check_val("auto_seq", bus.mode_out, (i / 3) % 6);
            bus.frame_start = 1'b0;
            repeat (2) tick();
        end

        // Three requests within one frame collapse into one step
        for (int k = 0; k < 3; k++) begin
            bus.step_req = 1'b1; tick();
            bus.step_req = 1'b0; tick();
        end
        frame(0);
        check_val("step_mode", bus.mode_out, 3);
        check_val("step_ack", bus.step_ack, 1);
        tick();
        frame(1);
        check_val("step_reload", bus.mode_out, 3);
        check_val("step_ack_once", bus.step_ack, 0);
        // Request coincident with frame_start
        bus.step_req = 1'b1;
        frame(0);
        bus.step_req = 1'b0;
        check_val("coinc_mode", bus.mode_out, 4);
        check_val("coinc_ack", bus.step_ack, 1);
        tick();

        // Auto to manual waits for a frame boundary
        bus.auto_en = 1'b0; bus.manual_mode = 3'd1;
        repeat (3) tick();
        check_val("a2m_hold", bus.mode_out, 4);
        frame(1);
        check_val("a2m_mode", bus.mode_out, 1);

        // Step request in manual is discarded
        bus.step_req = 1'b1; tick(); bus.step_req = 1'b0; tick();
        frame(1);
        check_val("man_step_ack", bus.step_ack, 0);
        bus.auto_en = 1'b1;
        frame(1);
        frame(0);
        check_val("man_step_none", bus.mode_out, 1);
        tick();

        // Palette scroll with wrap
        bus.auto_en = 1'b0; bus.manual_mode = 3'd0; bus.pal_base = 5'd30; bus.scroll_en = 1'b1;
        frame(1);
        check_val("pal_seq", bus.pal_out, pal_seq[0]);
        for (int i = 1; i < 6; i++) begin
            frame(1);
            check_val("pal_seq", bus.pal_out, pal_seq[i]);
        end
        bus.scroll_en = 1'b0;
        frame(1);
        check_val("pal_hold", bus.pal_out, 1);
        bus.scroll_en = 1'b1;
        frame(1);
        check_val("pal_divrst", bus.pal_out, 1);

        // Random stimulus
        for (int c = 0; c < 4000; c++) begin
            bus.frame_start = ($urandom_range(0, 3) == 0);
            bus.step_req    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 9) == 0) bus.manual_mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) bus.scroll_en = ~bus.scroll_en;
            if ($urandom_range(0, 29) == 0) bus.pal_base = 5'($urandom_range(0, 31));
            bus.ena = ($urandom_range(0, 59) != 0);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.ena = 1'b1;
        bus.frame_start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
